dca_matrix_lsu_rdata_collector: RTL and testbench

//  Read-data end of the DCA matrix LSU read path. The request side issues one AXI read burst per

---
 rtl/dca_matrix_lsu_rdata_collector.sv | 194 +++++++++++++++++++
 tb/tb_dca_matrix_lsu_rdata_collector.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_lsu_rdata_collector.sv
// dca_matrix_lsu_rdata_collector
//
// Read-data end of the DCA matrix LSU read path. Txn info {alen, is_last} is
// queued when the request side issues each AR. The block then consumes the
// R beats of each burst in order and counts them against the expected length.
// It forwards each beat through a one-entry output register, with txn-last and
// matrix-last flags attached. It pulses done one cycle after the matrix-last
// word is accepted.
//
// Optional build macro: DCA_RDATA_COLLECTOR_CHECK_EN
//   When defined, error becomes a sticky flag. It is set by an accepted beat
//   with a non-OKAY rresp, or by an accepted beat whose rlast disagrees with
//   the beat counter. When undefined, error is tied low and rlast/rresp are
//   ignored.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   clear              synchronous soft clear (flush queue, FSM idle, error 0)
//   txn_valid/ready    txn info push; ready = queue not full
//   txn_alen           expected beats-1 of the burst
//   txn_is_last        burst is the last of the matrix load
//   rvalid/rready      AXI R handshake
//   rdata/rlast/rresp  AXI R payload
//   out_valid/ready    output word handshake
//   out_data           output word
//   out_txn_last       word is the final beat of its txn
//   out_matrix_last    word is the final beat of the matrix load
//   busy               queue non-empty, FSM not idle, or output held
//   done               one-cycle pulse after the matrix-last word is accepted
//   error              sticky check flag (see macro above)
//
// state | meaning
// IDLE  | no txn in progress, waiting for queued txn info
// LOAD  | head txn latched into cur_alen/cur_last; R beats stalled
// RECV  | accepting R beats of the current burst

module dca_matrix_lsu_rdata_collector #(
   parameter int BW_AXI_DATA    = 32,
   parameter int BW_AXI_ALEN    = 8,
   parameter int TXN_FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   txn_valid,
   output logic                   txn_ready,
   input  logic [BW_AXI_ALEN-1:0] txn_alen,
   input  logic                   txn_is_last,
   input  logic                   rvalid,
   output logic                   rready,
   input  logic [BW_AXI_DATA-1:0] rdata,
   input  logic                   rlast,
   input  logic [1:0]             rresp,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BW_AXI_DATA-1:0] out_data,
   output logic                   out_txn_last,
   output logic                   out_matrix_last,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam int PTR_W = (TXN_FIFO_DEPTH > 1) ? $clog2(TXN_FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = BW_AXI_ALEN + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RECV = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ENT_W-1:0]       fifo_mem [TXN_FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       fifo_cnt;
   logic                   fifo_empty, fifo_full;
   logic                   push, pop;

   logic [BW_AXI_ALEN-1:0] cur_alen;
   logic                   cur_last;
   // One bit wider than alen so a 2^BW_AXI_ALEN-beat burst never wraps early.
   logic [BW_AXI_ALEN:0]   beat_cnt;
   logic                   beat_fire;
   logic                   beat_is_last;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_W'(TXN_FIFO_DEPTH));
   assign txn_ready  = !fifo_full;
   assign push       = txn_valid & txn_ready;

   assign rready       = (state == RECV) & (!out_valid | out_ready);
   assign beat_fire    = rvalid & rready;
   assign beat_is_last = (beat_cnt == {1'b0, cur_alen});

   assign busy = !fifo_empty | (state != IDLE) | out_valid;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: state_nxt = RECV;
         RECV: begin
            if (beat_fire && beat_is_last) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {txn_alen, txn_is_last};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state           <= IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_cnt        <= '0;
         cur_alen        <= '0;
         cur_last        <= 1'b0;
         beat_cnt        <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_txn_last    <= 1'b0;
         out_matrix_last <= 1'b0;
         done            <= 1'b0;
      end else begin
         state <= state_nxt;

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (pop) begin
            {cur_alen, cur_last} <= fifo_mem[rd_ptr];
            beat_cnt             <= '0;
         end else if (beat_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
         end

         // A new beat reloads the register even while the old word is being
         // accepted, so the output never bubbles within a burst.
         if (beat_fire) begin
            out_valid       <= 1'b1;
            out_data        <= rdata;
            out_txn_last    <= beat_is_last;
            out_matrix_last <= beat_is_last & cur_last;
         end else if (out_valid && out_ready) begin
            out_valid       <= 1'b0;
            out_txn_last    <= 1'b0;
            out_matrix_last <= 1'b0;
         end

         done <= out_valid & out_ready & out_matrix_last;
      end
   end

`ifdef DCA_RDATA_COLLECTOR_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         error <= 1'b0;
      end else if (beat_fire && ((rresp != 2'b00) || (rlast != beat_is_last))) begin
         error <= 1'b1;
      end
   end
`else
   logic unused_chk;
   assign unused_chk = ^{rlast, rresp};
   assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_dca_matrix_lsu_rdata_collector.sv
module tb_dca_matrix_lsu_rdata_collector;

   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst, clear;
   logic          txn_valid, txn_ready, txn_is_last;
   logic [AW-1:0] txn_alen;
   logic          rvalid, rready, rlast;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          out_valid, out_ready, out_txn_last, out_matrix_last;
   logic [DW-1:0] out_data;
   logic          busy, done, error;

   always #5 clk = ~clk;

   dca_matrix_lsu_rdata_collector #(
      .BW_AXI_DATA   (DW),
      .BW_AXI_ALEN   (AW),
      .TXN_FIFO_DEPTH(4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .txn_valid      (txn_valid),
      .txn_ready      (txn_ready),
      .txn_alen       (txn_alen),
      .txn_is_last    (txn_is_last),
      .rvalid         (rvalid),
      .rready         (rready),
      .rdata          (rdata),
      .rlast          (rlast),
      .rresp          (rresp),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_txn_last   (out_txn_last),
      .out_matrix_last(out_matrix_last),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   typedef struct {
      logic [AW-1:0] alen;
      logic          last;
   } txn_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          rlast;
      logic [1:0]    rresp;
      logic          tl;
      logic          ml;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          tl;
      logic          ml;
   } exp_t;

   typedef struct {
      int            alen;
      int            n_txn;
      int            ready_mode;  // 0 always ready, 1 toggle, 2 random
      int            bad_resp;    // beat index of first txn with SLVERR, -1 none
      int            bad_rlast;   // beat index of first txn with flipped rlast, -1 none
      int            r_start;     // cycle at which rvalid may first assert
      int            full_chk;    // cycle at which txn_ready must be 0, -1 none
      bit            exact_gap;
      logic [DW-1:0] base;
   } vec_t;

   txn_t  txn_q[$];
   beat_t beat_q[$];
   exp_t  sb[$];
   vec_t  vecs[7];

   int   checks = 0;
   int   errors = 0;
   bit   chk_en;
   logic err_exp;
   logic done_exp;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic idle_inputs();
      clear       = 1'b0;
      txn_valid   = 1'b0;
      txn_alen    = '0;
      txn_is_last = 1'b0;
      rvalid      = 1'b0;
      rdata       = '0;
      rlast       = 1'b0;
      rresp       = 2'b00;
      out_ready   = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_out_valid"}, DW'(out_valid), 0);
      chk({tag, "_busy"}, DW'(busy), 0);
      chk({tag, "_txn_ready"}, DW'(txn_ready), 1);
      chk({tag, "_error"}, DW'(error), 0);
      chk({tag, "_done"}, DW'(done), 0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      idle_inputs();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      check_quiet("clear");
      err_exp  = 1'b0;
      done_exp = 1'b0;
   endtask

   task automatic add_txn(input int alen, input bit last, input logic [DW-1:0] base,
                          input int bad_resp, input int bad_rlast);
      txn_t t;
      t.alen = AW'(alen);
      t.last = last;
      txn_q.push_back(t);
      for (int i = 0; i <= alen; i++) begin
         beat_t b;
         b.data  = base + DW'(i);
         b.tl    = (i == alen);
         b.ml    = b.tl & last;
         b.rlast = b.tl ^ (i == bad_rlast);
         b.rresp = (i == bad_resp) ? 2'b10 : 2'b00;
         beat_q.push_back(b);
      end
   endtask

   task automatic run_scenario(input int ready_mode, input int r_start, input int full_chk,
                               input bit exact_gap, input string tag);
      int cyc       = 0;
      int words     = 0;
      int exp_words = beat_q.size();
      int max_cyc   = exp_words * 4 + 60;
      int last_r    = -1;
      bit prev_tl   = 1'b0;
      while ((txn_q.size() > 0 || beat_q.size() > 0 || sb.size() > 0 || out_valid) &&
             cyc < max_cyc) begin
         @(negedge clk);
         txn_valid = (txn_q.size() > 0);
         if (txn_valid) begin
            txn_alen    = txn_q[0].alen;
            txn_is_last = txn_q[0].last;
         end
         rvalid = (cyc >= r_start) && (beat_q.size() > 0);
         if (rvalid) begin
            rdata = beat_q[0].data;
            rlast = beat_q[0].rlast;
            rresp = beat_q[0].rresp;
         end else begin
            rlast = 1'b0;
            rresp = 2'b00;
         end
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = cyc[0];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         chk({tag, "_done"}, DW'(done), DW'(done_exp));
         chk({tag, "_error"}, DW'(error), DW'(err_exp));
         if (out_valid && !out_ready) chk({tag, "_rready_stall"}, DW'(rready), 0);
         if (cyc == full_chk) chk({tag, "_queue_full"}, DW'(txn_ready), 0);

         if (txn_valid && txn_ready) void'(txn_q.pop_front());

         done_exp = 1'b0;
         if (out_valid && out_ready) begin
            words++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL %s_spurious_word: got %0h expected no word", tag, out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({tag, "_data"}, out_data, e.data);
               chk({tag, "_txn_last"}, DW'(out_txn_last), DW'(e.tl));
               chk({tag, "_matrix_last"}, DW'(out_matrix_last), DW'(e.ml));
               done_exp = e.ml;
            end
         end

         if (rvalid && rready) begin
            beat_t b;
            exp_t  e;
            b = beat_q.pop_front();
            e.data = b.data;
            e.tl   = b.tl;
            e.ml   = b.ml;
            sb.push_back(e);
            if (chk_en && ((b.rresp != 2'b00) || (b.rlast != b.tl))) err_exp = 1'b1;
            if (exact_gap && last_r >= 0) chk({tag, "_r_gap"}, DW'(cyc - last_r), prev_tl ? 2 : 1);
            last_r  = cyc;
            prev_tl = b.tl;
         end
         cyc++;
      end
      @(negedge clk);
      idle_inputs();
      #1;
      chk({tag, "_complete"}, DW'(txn_q.size() + beat_q.size() + sb.size()), 0);
      chk({tag, "_word_count"}, DW'(words), DW'(exp_words));
      chk({tag, "_end_done"}, DW'(done), DW'(done_exp));
      chk({tag, "_end_error"}, DW'(error), DW'(err_exp));
      chk({tag, "_end_busy"}, DW'(busy), 0);
      txn_q.delete();
      beat_q.delete();
      sb.delete();
      done_exp = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int fired;
      int cyc;
`ifdef DCA_RDATA_COLLECTOR_CHECK_EN
      chk_en = 1'b1;
`else
      chk_en = 1'b0;
`endif
      err_exp  = 1'b0;
      done_exp = 1'b0;

      //        alen n  mode resp rlast rst full gap base
      vecs[0] = '{3,   1, 0,  -1,  -1,   0,  -1,  1, 32'h0000_00A0};
      vecs[1] = '{0,   6, 0,  -1,  -1,   8,   5,  1, 32'h0000_1000};
      vecs[2] = '{7,   1, 1,  -1,  -1,   0,  -1,  0, 32'h0000_0070};
      vecs[3] = '{255, 1, 0,  -1,  -1,   0,  -1,  1, 32'h0001_0000};
      vecs[4] = '{1,   1, 0,   1,  -1,   0,  -1,  1, 32'h0000_00B0};
      vecs[5] = '{2,   1, 0,  -1,   0,   0,  -1,  1, 32'h0000_00C0};
      vecs[6] = '{2,   3, 2,  -1,  -1,   0,  -1,  0, 32'h0000_0D00};

      idle_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_rready", DW'(rready), 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_txn_last", DW'(out_txn_last), 0);
      chk("reset_out_matrix_last", DW'(out_matrix_last), 0);
      check_quiet("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         do_clear();
         for (int k = 0; k < vecs[v].n_txn; k++) begin
            add_txn(vecs[v].alen, (k == vecs[v].n_txn - 1), vecs[v].base + DW'(k * 256),
                    (k == 0) ? vecs[v].bad_resp : -1, (k == 0) ? vecs[v].bad_rlast : -1);
         end
         run_scenario(vecs[v].ready_mode, vecs[v].r_start, vecs[v].full_chk,
                      vecs[v].exact_gap, tag);
      end

      // Clear in the middle of a 6-beat burst with two txns still queued.
      do_clear();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         txn_valid   = 1'b1;
         txn_alen    = (k == 0) ? AW'(5) : AW'(1);
         txn_is_last = (k == 2);
         #1;
         chk("clr_push_ready", DW'(txn_ready), 1);
      end
      @(negedge clk);
      txn_valid = 1'b0;
      fired     = 0;
      cyc       = 0;
      while (fired < 2 && cyc < 40) begin
         @(negedge clk);
         rvalid    = 1'b1;
         rdata     = 32'hE0 + DW'(fired);
         rlast     = 1'b0;
         rresp     = 2'b00;
         out_ready = 1'b1;
         #1;
         if (rvalid && rready) fired++;
         cyc++;
      end
      chk("clr_beats_before_clear", DW'(fired), 2);
      @(negedge clk);
      clear = 1'b1;
      rdata = 32'hE2;
      @(negedge clk);
      idle_inputs();
      #1;
      check_quiet("clr_mid_burst");
      err_exp  = 1'b0;
      done_exp = 1'b0;
      add_txn(2, 1'b1, 32'h0000_0F00, -1, -1);
      run_scenario(0, 0, -1, 1'b1, "clr_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
